// File: rtl/crossbar_scheduler.sv
// Round-robin packet scheduler for a 4x4 byte crossbar: one IDLE/XFER FSM per output port.
// Define SCHED_STATS_EN to add per-output completed-packet counters on stat_pkts.
module crossbar_scheduler #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = DATA_W - 2,
    parameter int SEL_W  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sched_en,
    input  logic [3:0]          port_mask,
    input  logic [3:0]          empty,
    input  logic [4*DATA_W-1:0] q_flat,
    input  logic [3:0]          out_ready,
    output logic [3:0]          rdreq,
    output logic [4*SEL_W-1:0]  sel_flat,
    output logic [3:0]          out_valid,
    output logic [3:0]          out_sop,
    output logic [3:0]          out_eop,
    output logic [3:0]          busy
`ifdef SCHED_STATS_EN
    ,
    output logic [4*16-1:0]     stat_pkts
`endif
);

    localparam int N = 4;
    localparam logic [SEL_W-1:0] SEL_IDLE = SEL_W'(4);

    typedef enum logic {IDLE, XFER} state_t;

    state_t            state_q [N];
    state_t            state_d [N];
    logic [1:0]        src_q   [N];
    logic [1:0]        src_d   [N];
    logic [LEN_W:0]    left_q  [N];
    logic [LEN_W:0]    left_d  [N];
    logic              first_q [N];
    logic              first_d [N];
    logic [1:0]        rr_q    [N];
    logic [1:0]        rr_d    [N];
    logic [N-1:0]      lock_q;
    logic [N-1:0]      lock_d;
    logic [DATA_W-1:0] head    [N];
    logic [N-1:0]      req     [N];
    logic [2:0]        pick    [N];
    logic [N-1:0]      beat;

    // Returns {found, index}: first set request at or after ptr, wrapping mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [LEN_W:0] pkt_beats(input logic [LEN_W-1:0] len);
        return {1'b0, len} + (LEN_W+1)'(1);
    endfunction

    always_comb begin
        lock_d = lock_q;
        beat   = '0;
        for (int i = 0; i < N; i++) begin
            head[i] = q_flat[i*DATA_W +: DATA_W];
        end
        for (int o = 0; o < N; o++) begin
            state_d[o] = state_q[o];
            src_d[o]   = src_q[o];
            left_d[o]  = left_q[o];
            first_d[o] = first_q[o];
            rr_d[o]    = rr_q[o];
            // Registered lock means an input freed this cycle is only re-grantable next cycle.
            for (int i = 0; i < N; i++) begin
                req[o][i] = !empty[i] && !lock_q[i] && (head[i][DATA_W-1 -: 2] == 2'(o))
                            && port_mask[o] && sched_en;
            end
            pick[o] = rr_pick(req[o], rr_q[o]);
            case (state_q[o])
                IDLE: begin
                    if (pick[o][2]) begin
                        state_d[o]          = XFER;
                        src_d[o]            = pick[o][1:0];
                        left_d[o]           = pkt_beats(head[pick[o][1:0]][LEN_W-1:0]);
                        first_d[o]          = 1'b1;
                        lock_d[pick[o][1:0]] = 1'b1;
                    end
                end
                XFER: begin
                    beat[o] = !empty[src_q[o]] && out_ready[o];
                    if (beat[o]) begin
                        left_d[o]  = left_q[o] - (LEN_W+1)'(1);
                        first_d[o] = 1'b0;
                        if (left_q[o] == (LEN_W+1)'(1)) begin
                            state_d[o]       = IDLE;
                            lock_d[src_q[o]] = 1'b0;
                            rr_d[o]          = src_q[o] + 2'd1;
                        end
                    end
                end
                default: state_d[o] = IDLE;
            endcase
        end
    end

    always_comb begin
        rdreq     = '0;
        sel_flat  = '0;
        out_valid = beat;
        out_sop   = '0;
        out_eop   = '0;
        busy      = '0;
        for (int o = 0; o < N; o++) begin
            busy[o]    = (state_q[o] == XFER);
            sel_flat[o*SEL_W +: SEL_W] = busy[o] ? SEL_W'(src_q[o]) : SEL_IDLE;
            out_sop[o] = beat[o] && first_q[o];
            out_eop[o] = beat[o] && (left_q[o] == (LEN_W+1)'(1));
            if (beat[o]) rdreq[src_q[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q <= '0;
            for (int o = 0; o < N; o++) begin
                state_q[o] <= IDLE;
                src_q[o]   <= '0;
                left_q[o]  <= '0;
                first_q[o] <= 1'b0;
                rr_q[o]    <= '0;
            end
        end else begin
            lock_q <= lock_d;
            for (int o = 0; o < N; o++) begin
                state_q[o] <= state_d[o];
                src_q[o]   <= src_d[o];
                left_q[o]  <= left_d[o];
                first_q[o] <= first_d[o];
                rr_q[o]    <= rr_d[o];
            end
        end
    end

`ifdef SCHED_STATS_EN
    logic [15:0] pkt_cnt_q [N];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int o = 0; o < N; o++) pkt_cnt_q[o] <= '0;
        end else begin
            for (int o = 0; o < N; o++) begin
                if (out_eop[o]) pkt_cnt_q[o] <= pkt_cnt_q[o] + 16'd1;
            end
        end
    end

    always_comb begin
        stat_pkts = '0;
        for (int o = 0; o < N; o++) stat_pkts[o*16 +: 16] = pkt_cnt_q[o];
    end
`endif

endmodule
